// File: rtl/avg_decimator.sv
// Integrate-and-dump decimator: averages 2^LOG2_DECIM signed samples per block and
// buffers the rounded results in a FIFO. Define AVG_DECIM_OVF_EN to add o_overflow.
module avg_decimator #(
  parameter int LOG2_DECIM = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [15:0]                         i_data,
  input  logic                                i_valid,
  input  logic                                i_sync,
  output logic [15:0]                         o_data,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_fill
`ifdef AVG_DECIM_OVF_EN
  ,
  output logic                                o_overflow
`endif
);

  localparam int DATA_W = 16;
  localparam int N      = 1 << LOG2_DECIM;
  localparam int ACC_W  = DATA_W + LOG2_DECIM;
  localparam int CNT_W  = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam int HALF   = N >> 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FIFO_DEPTH);

  // Round half up; the accumulator is wide enough that the bias never overflows.
  function automatic logic signed [DATA_W-1:0] round_avg(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] biased;
    biased = sum + ACC_W'(HALF);
    biased = biased >>> LOG2_DECIM;
    return biased[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] data_s;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_base_p0, sum_p0;
  logic [CNT_W-1:0]         cnt_base_p0;
  logic                     dump_p0;

  logic signed [ACC_W-1:0]  sum_p1_q;
  logic                     vld_p1_q;
  logic signed [DATA_W-1:0] avg_p1;

  logic [DATA_W-1:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         rd_ptr_q, wr_ptr_q;
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic                     full, pop, wr_en, drop;

  assign data_s = i_data;

  // ---- stage p0: accumulate / dump ----
  always_comb begin
    acc_base_p0 = i_sync ? '0 : acc_q;
    cnt_base_p0 = i_sync ? '0 : cnt_q;
    sum_p0      = acc_base_p0 + ACC_W'(data_s);
    dump_p0     = i_valid && (cnt_base_p0 == CNT_LAST);
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (i_sync) begin
      acc_d = '0;
      cnt_d = '0;
    end
    if (i_valid) begin
      if (dump_p0) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum_p0;
        cnt_d = cnt_base_p0 + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      vld_p1_q <= dump_p0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (dump_p0) sum_p1_q <= sum_p0;
  end

  // ---- stage p1: round and push into FIFO ----
  assign avg_p1 = round_avg(sum_p1_q);

  assign o_valid = (fill_q != '0);
  assign full    = (fill_q == FILL_FULL);
  assign pop     = o_valid && i_ready;
  // When full, a simultaneous pop frees the slot the push lands in (wr_ptr == rd_ptr).
  assign wr_en   = vld_p1_q && (!full || pop);
  assign drop    = vld_p1_q && full && !pop;

  always_comb begin
    fill_d = fill_q;
    case ({wr_en, pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= avg_p1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fill_q <= fill_d;
    end
  end

  // Storage is not reset, so mask the head while empty.
  assign o_data = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_fill = fill_q;

`ifdef AVG_DECIM_OVF_EN
  logic ovf_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)     ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  assign o_overflow = ovf_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_avg_decimator.sv
// Scoreboard bench for avg_decimator (N=4, FIFO_DEPTH=4) with directed vectors.
module tb_avg_decimator;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [15:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_sync = 1'b0;
  logic        i_ready = 1'b0;
  logic [15:0] o_data;
  logic        o_valid;
  logic [2:0]  o_fill;
`ifdef AVG_DECIM_OVF_EN
  logic        o_overflow;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  avg_decimator #(.LOG2_DECIM(2), .FIFO_DEPTH(4)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_sync  (i_sync),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_fill  (o_fill)
`ifdef AVG_DECIM_OVF_EN
    ,
    .o_overflow (o_overflow)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted output is compared against the scoreboard head.
  always @(negedge i_clk) begin
    if (o_valid === 1'b1 && i_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %0d, expected no output", $signed(o_data));
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'($signed(o_data)) !== e) begin
          errors++;
          $display("FAIL sb_data: got %0d, expected %0d", $signed(o_data), e);
        end
      end
    end
  end

  // Present one input cycle; returns 1 time unit after the sampling edge.
  task automatic drive(input logic v, input int d, input logic s);
    i_valid = v;
    i_data  = 16'(d);
    i_sync  = s;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_sync  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b0);
  endtask

  task automatic feed4(input int a, input int b, input int c, input int d, input int avg);
    drive(1'b1, a, 1'b0);
    drive(1'b1, b, 1'b0);
    drive(1'b1, c, 1'b0);
    exp_q.push_back(avg);
    drive(1'b1, d, 1'b0);
  endtask

  initial begin
    idle(2);
    i_rst = 1'b0;
    check("rst_valid", o_valid, 0);
    check("rst_fill", o_fill, 0);
    check("rst_data", o_data, 0);
`ifdef AVG_DECIM_OVF_EN
    check("rst_ovf", o_overflow, 0);
`endif

    // Basic block with latency
    i_ready = 1'b1;
    feed4(1, 2, 3, 4, 3);
    check("lat_c1_valid", o_valid, 0);
    idle(1);
    check("lat_c2_valid", o_valid, 1);
    check("lat_c2_data", int'($signed(o_data)), 3);
    check("lat_c2_fill", o_fill, 1);
    idle(1);
    check("lat_c3_fill", o_fill, 0);
    check("lat_c3_valid", o_valid, 0);

    // Extremes and rounding corners, back to back
    feed4(32767, 32767, 32767, 32767, 32767);
    feed4(-32768, -32768, -32768, -32768, -32768);
    feed4(-1, -1, -1, -2, -1);
    feed4(2, 0, 0, 0, 1);
    feed4(-2, 0, 0, 0, 0);
    feed4(-3, 0, 0, 0, -1);
    feed4(1, 1, 1, 0, 1);
    idle(4);

    // Gapped input
    drive(1'b1, 8, 1'b0);
    drive(1'b1, 8, 1'b0);
    idle(5);
    drive(1'b1, 8, 1'b0);
    exp_q.push_back(8);
    drive(1'b1, 8, 1'b0);
    check("gap_c1_valid", o_valid, 0);
    idle(1);
    check("gap_c2_valid", o_valid, 1);
    check("gap_c2_data", int'($signed(o_data)), 8);
    idle(3);

    // Sync with a valid sample starts a new block
    drive(1'b1, 100, 1'b0);
    drive(1'b1, 100, 1'b0);
    drive(1'b1, 4, 1'b1);
    drive(1'b1, 4, 1'b0);
    drive(1'b1, 4, 1'b0);
    exp_q.push_back(4);
    drive(1'b1, 4, 1'b0);
    idle(4);
    // Sync alone just discards
    drive(1'b1, 5, 1'b0);
    drive(1'b1, 5, 1'b0);
    drive(1'b0, 0, 1'b1);
    feed4(6, 6, 6, 6, 6);
    idle(4);
    check("sync_fill", o_fill, 0);

    // Full FIFO with simultaneous push and pop
    i_ready = 1'b0;
    feed4(10, 10, 10, 10, 10);
    feed4(20, 20, 20, 20, 20);
    feed4(30, 30, 30, 30, 30);
    feed4(40, 40, 40, 40, 40);
    idle(3);
    check("full_fill", o_fill, 4);
    feed4(50, 50, 50, 50, 50);
    i_ready = 1'b1;
    idle(1);
    check("pushpop_fill", o_fill, 4);
`ifdef AVG_DECIM_OVF_EN
    check("pushpop_ovf", o_overflow, 0);
`endif
    idle(6);
    check("pushpop_drain_fill", o_fill, 0);

    // Back-pressure with drops
    i_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, k, 1'b0);
      drive(1'b1, k, 1'b0);
      drive(1'b1, k, 1'b0);
      if (k <= 4) exp_q.push_back(k);
      drive(1'b1, k, 1'b0);
    end
    idle(3);
    check("bp_fill", o_fill, 4);
    check("bp_valid", o_valid, 1);
    check("bp_head", int'($signed(o_data)), 1);
`ifdef AVG_DECIM_OVF_EN
    check("bp_ovf", o_overflow, 1);
`endif
    idle(2);
    check("bp_head_stable", int'($signed(o_data)), 1);
    i_ready = 1'b1;
    idle(6);
    check("bp_drain_valid", o_valid, 0);
    check("bp_drain_fill", o_fill, 0);

    // Reset mid-operation
    i_ready = 1'b0;
    feed4(7, 7, 7, 7, 0);
    feed4(8, 8, 8, 8, 0);
    feed4(9, 9, 9, 9, 0);
    idle(3);
    check("mid_fill", o_fill, 3);
    exp_q.delete();
    drive(1'b1, 5, 1'b0);
    drive(1'b1, 5, 1'b0);
    i_rst = 1'b1;
    drive(1'b1, 5, 1'b0);
    i_rst = 1'b0;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_fill", o_fill, 0);
    check("mid_rst_data", o_data, 0);
`ifdef AVG_DECIM_OVF_EN
    check("mid_rst_ovf", o_overflow, 0);
`endif
    i_ready = 1'b1;
    feed4(10, 20, 30, 41, 25);
    check("post_rst_c1_valid", o_valid, 0);
    idle(1);
    check("post_rst_c2_valid", o_valid, 1);
    check("post_rst_c2_data", int'($signed(o_data)), 25);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
    idle(2);
    check("sb_drained", exp_q.size(), 0);
    check("end_valid", o_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
